instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-stage initiator for the synchronous instruction memory. Holds the PC and issues
//  word-addressed read requests. Buffers returned instructions with their PCs in a small
//  FIFO and presents them to decode with a valid/ready handshake.
//  Accepts branch/jump redirects from later stages and flushes stale fetches.
// PARAMETERS
//  ADDR_W      32  PC / imem address width; addresses are instruction indices (+1 per instr)
//  DATA_W      32  instruction width
//  FIFO_DEPTH  4   prefetch buffer entries (power of 2, >=2)
//  RESET_PC    0   PC loaded on reset
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  imem_req        out  1       read request this cycle
//  imem_addr       out  ADDR_W  request address (valid when imem_req)
//  imem_instr      in   DATA_W  read data; valid exactly 1 cycle after the request
//  redirect_valid  in   1       load new PC, flush pipeline
//  redirect_pc     in   ADDR_W  target PC
//  if_valid        out  1       if_instr/if_pc valid
//  if_ready        in   1       decode accepts the entry
//  if_instr        out  DATA_W  instruction at FIFO head
//  if_pc           out  ADDR_W  PC of if_instr
//  fifo_level      out  clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, no request in flight.
//    imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=RESET_PC, fifo_level=0.
//  - Credit rule: imem_req=1 iff !redirect_valid && (fifo_level + inflight) < FIFO_DEPTH.
//    inflight (0/1) = valid request issued last cycle, not squashed.
//  - imem_req and imem_addr are registered outputs. The first request is in the first
//    rising edge after rst_n deasserts; imem_addr=pc. On issue, pc <= pc+1, wrapping
//    modulo 2^ADDR_W.
//  - Response: the cycle after an unsquashed request, imem_instr and its PC are pushed
//    into the FIFO.
//  - Pop: occurs when if_valid && if_ready. if_valid = FIFO non-empty.
//    Push and pop can occur in the same cycle, including when full; the credit rule
//    guarantees no overflow. Pop when empty and push when full are impossible; both are
//    flagged by an assertion.
//  - Redirect (priority over all else):
//    - A handshake in the redirect cycle completes normally.
//    - The edge then empties the FIFO and sets pc <= redirect_pc.
//    - The in-flight request is squashed and its response is dropped.
//    - No request is issued in the redirect cycle. The request for redirect_pc issues on
//      the next cycle, and if_valid rises 2 cycles after that issue (latency 1 + FIFO).
//  - Back-to-back redirects: the last one wins; each cycle re-flushes.
//  - Steady state: with if_ready held high, one instruction per cycle.
//  - Reset mid-operation: asynchronous clear of all state to reset values; nothing is
//    retained.
// CONFIGURATION
//  IFU_BYPASS_EN defined:
//    - When the FIFO is empty and a valid response arrives, it is presented combinationally
//      that cycle: if_valid=1, if_instr=imem_instr.
//    - If if_ready=1, it is consumed without entering the FIFO; otherwise it is pushed.
//    - Redirect-to-first-if_valid drops to 1 cycle after issue.
//  IFU_BYPASS_EN undefined:
//    - All responses go through the FIFO; if_* outputs come from registers only
//      (1 extra cycle of latency).
// TESTING
//  1. Reset release, imem preloaded 0..12, if_ready=1 -> imem_addr 0,1,2,... on
//     consecutive cycles; if_pc increments by 1 with matching if_instr; no gaps after
//     fill.
//  2. if_ready=0 for 10 cycles -> fifo_level saturates at 4, imem_req stays 0 after 4
//     issues. Release -> PCs 0..3 delivered in order, then 4 follows with no duplicate or
//     loss.
//  3. FIFO full, redirect_valid pulse with redirect_pc=12 -> fifo_level=0 next cycle,
//     squashed response not seen. Next delivered if_pc=12, instr=imem[12].
//  4. Redirect to 9 in a cycle with if_valid&&if_ready, if_pc=3 -> PC 3 counted as
//     consumed. Next delivered if_pc=9. Redirects to 5 then 7 on consecutive cycles ->
//     first delivered if_pc=7.
//  5. rst_n low asynchronously mid-stream, between edges -> outputs drop to reset values
//     immediately. After release, fetch restarts at RESET_PC=0.
//  6. PC at 2^ADDR_W-1 via redirect -> next request address 0 (wrap). With IFU_BYPASS_EN,
//     empty FIFO + if_ready=1 -> if_valid asserted the same cycle the response returns.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch-stage initiator: PC, credit-limited imem requests, prefetch FIFO, decode handshake.
// Optional IFU_BYPASS_EN: an empty FIFO forwards the returning instruction to decode combinationally.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [DATA_W-1:0]             imem_instr,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [DATA_W-1:0]             if_instr,
  output logic [ADDR_W-1:0]             if_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic              resp_vld;
  logic [ADDR_W-1:0] resp_pc;
  logic [DATA_W-1:0] mem_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              fifo_empty, push, pop, credit_ok;
`ifdef IFU_BYPASS_EN
  logic              bypass;
`endif

  always_comb begin
    fifo_empty = (level == '0);
`ifdef IFU_BYPASS_EN
    // A returning word with nothing queued ahead of it goes straight to decode.
    bypass   = fifo_empty && resp_vld;
    if_valid = !fifo_empty || bypass;
    if (!fifo_empty) begin
      if_instr = mem_instr[rd_ptr];
      if_pc    = mem_pc[rd_ptr];
    end else if (bypass) begin
      if_instr = imem_instr;
      if_pc    = resp_pc;
    end else begin
      if_instr = '0;
      if_pc    = RESET_PC;
    end
    pop  = if_valid && if_ready && !fifo_empty;
    push = resp_vld && !redirect_valid && !(bypass && if_ready);
`else
    if_valid = !fifo_empty;
    if_instr = fifo_empty ? '0 : mem_instr[rd_ptr];
    if_pc    = fifo_empty ? RESET_PC : mem_pc[rd_ptr];
    pop      = if_valid && if_ready;
    push     = resp_vld && !redirect_valid;
`endif
    level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    // The request currently on the bus becomes next cycle's in-flight word.
    credit_ok = (level_nxt + LVL_W'(imem_req)) < LVL_W'(FIFO_DEPTH);
  end

  assign fifo_level = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      resp_vld  <= 1'b0;
      resp_pc   <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      resp_vld <= imem_req && !redirect_valid;
      resp_pc  <= imem_addr;
      if (redirect_valid) begin
        level     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
        pc        <= redirect_pc + ADDR_W'(1);
      end else begin
        level <= level_nxt;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (credit_ok) begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          pc        <= pc + ADDR_W'(1);
        end else begin
          imem_req  <= 1'b0;
        end
      end
    end
  end

  // Queue storage carries data only; occupancy lives in level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_instr;
      mem_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && level == LVL_W'(FIFO_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && level == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: imem model plus an in-order stream scoreboard.
module tb_instr_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [AW-1:0] exp_pc = '0;
  logic [AW-1:0] exp_req = '0;
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fifo_level(fifo_level)
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a * 32'h0100_0193 + 32'h1234_5678;
  endfunction

  // Synchronous instruction memory: data one cycle after the request, junk otherwise.
  always @(posedge clk) imem_instr <= imem_req ? mem_f(imem_addr) : DW'($urandom());

  // One clock with the currently driven inputs; the reference stream is advanced mid-cycle.
  task automatic cycle();
    @(negedge clk);
    if (sb_on) begin
      if (imem_req) begin
        checks++;
        if (imem_addr !== exp_req) begin
          errors++;
          $display("FAIL req_addr got %h want %h", imem_addr, exp_req);
        end
        exp_req = exp_req + 1;
      end
      if (redirect_valid) exp_req = redirect_pc;
      if (if_valid && if_ready) begin
        checks++;
        if (if_pc !== exp_pc || if_instr !== mem_f(exp_pc)) begin
          errors++;
          $display("FAIL stream got pc=%h instr=%h want pc=%h instr=%h",
                   if_pc, if_instr, exp_pc, mem_f(exp_pc));
        end
        exp_pc = exp_pc + 1;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== '0) begin errors++; $display("FAIL rst_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== '0) begin errors++; $display("FAIL rst_pc got %h want 0", if_pc); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = '0;
    exp_req = '0;
    sb_on = 1'b1;
  endtask

  task automatic test_stream();
    int gaps, d0;
    if_ready = 1'b1;
    repeat (5) cycle();
    gaps = 0;
    d0 = delivered;
    repeat (16) begin
      if (!if_valid) gaps++;
      cycle();
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
    checks++; if (delivered - d0 != 16) begin errors++; $display("FAIL stream_rate got %0d want 16", delivered - d0); end
  endtask

  task automatic test_backpressure();
    int reqs, d0;
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = '0;
    cycle();
    redirect_valid = 1'b0;
    reqs = 0;
    repeat (10) begin
      if (imem_req) reqs++;
      cycle();
    end
    checks++; if (reqs != 4) begin errors++; $display("FAIL bp_issues got %0d want 4", reqs); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d want 4", fifo_level); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b want 0", imem_req); end
    if_ready = 1'b1;
    d0 = delivered;
    repeat (12) cycle();
    checks++; if (delivered - d0 < 8) begin errors++; $display("FAIL bp_drain got %0d want >=8", delivered - d0); end
  endtask

  task automatic test_redirect_full();
    int k;
    if_ready = 1'b0;
    repeat (8) cycle();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
    redirect_valid = 1'b1;
    redirect_pc = 32'd12;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", fifo_level); end
    if_ready = 1'b1;
    k = 0;
    while (!if_valid && k < 10) begin cycle(); k++; end
    checks++; if (k != (BYPASS ? 1 : 2)) begin errors++; $display("FAIL redir_latency got %0d want %0d", k, BYPASS ? 1 : 2); end
    checks++; if (if_pc !== 32'd12 || if_instr !== mem_f(32'd12)) begin
      errors++; $display("FAIL redir_first got pc=%h instr=%h want pc=0000000c instr=%h", if_pc, if_instr, mem_f(32'd12));
    end
    repeat (4) cycle();
  endtask

  task automatic test_redirect_handshake();
    int k, d0;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = '0;
    cycle();
    redirect_valid = 1'b0;
    k = 0;
    while (!(if_valid && if_pc == 32'd3) && k < 20) begin cycle(); k++; end
    checks++; if (k >= 20) begin errors++; $display("FAIL hs_wait got timeout want pc 3"); end
    redirect_valid = 1'b1;
    redirect_pc = 32'd9;
    d0 = delivered;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (delivered - d0 != 1) begin errors++; $display("FAIL hs_consumed got %0d want 1", delivered - d0); end
    k = 0;
    while (!if_valid && k < 10) begin cycle(); k++; end
    checks++; if (if_pc !== 32'd9) begin errors++; $display("FAIL hs_next got %h want 00000009", if_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    cycle();
    redirect_pc = 32'd7;
    cycle();
    redirect_valid = 1'b0;
    k = 0;
    while (!if_valid && k < 10) begin cycle(); k++; end
    checks++; if (if_pc !== 32'd7 || if_instr !== mem_f(32'd7)) begin
      errors++; $display("FAIL b2b_redir got pc=%h instr=%h want pc=00000007", if_pc, if_instr);
    end
    repeat (3) cycle();
  endtask

  task automatic test_async_reset();
    int k;
    if_ready = 1'b1;
    repeat (6) cycle();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", if_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL arst_addr got %h want 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", if_valid); end
    checks++; if (if_pc !== '0 || if_instr !== '0) begin errors++; $display("FAIL arst_if got pc=%h instr=%h want 0", if_pc, if_instr); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d want 0", fifo_level); end
    sb_on = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = '0;
    exp_req = '0;
    sb_on = 1'b1;
    k = 0;
    while (!if_valid && k < 10) begin cycle(); k++; end
    checks++; if (if_pc !== '0 || if_valid !== 1'b1) begin errors++; $display("FAIL restart got pc=%h valid=%b want pc=0 valid=1", if_pc, if_valid); end
    repeat (4) cycle();
  endtask

  task automatic test_wrap();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_top got req=%b addr=%h want req=1 addr=ffffffff", imem_req, imem_addr);
    end
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin
      errors++; $display("FAIL wrap_zero got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    checks++; if (if_valid !== BYPASS) begin errors++; $display("FAIL bypass_same_cycle got %b want %b", if_valid, BYPASS); end
    repeat (5) cycle();
  endtask

  task automatic test_random();
    int d0;
    d0 = delivered;
    repeat (400) begin
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 40))
                                                  : 32'hFFFF_FFF0 + AW'($urandom_range(0, 15));
      end else begin
        redirect_valid = 1'b0;
      end
      cycle();
      checks++; if (fifo_level > 3'd4) begin errors++; $display("FAIL rand_level got %0d want <=4", fifo_level); end
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    repeat (6) cycle();
    checks++; if (delivered - d0 < 100) begin errors++; $display("FAIL rand_progress got %0d want >=100", delivered - d0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_handshake();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
